// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display driver:
// conversion FSM states, active-low segment patterns and digit-enable values.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Segment patterns are active-low with bit 6 = a and bit 0 = g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam int SHIFT_COUNT = 13;

  // Double-dabble correction applied to a BCD nibble before each shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern decoder.
module seg7_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_display_driver.sv
// Converts a 13-bit binary value to BCD with a free-running 15-cycle
// double-dabble FSM and time-multiplexes the four digits onto the display.
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int DATA_W       = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  output logic [3:0]        Anode,
  output logic [6:0]        LED_out,
  output logic              digits_valid
);

  localparam logic [3:0] LAST_SHIFT = 4'(SHIFT_COUNT - 1);

  state_t                   state, next_state;
  logic [3:0]               count;
  logic [15+DATA_W:0]       shift_reg;
  logic [15:0]              bcd_adj;
  logic [15:0]              digits;
  logic [REFRESH_BITS-1:0]  cnt;
  logic [1:0]               sel;
  logic [3:0]               cur_digit;
  logic [3:0]               anode_next;
  logic [6:0]               seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = SHIFT;
      SHIFT:   if (count == LAST_SHIFT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++)
      bcd_adj[i*4 +: 4] = add3(shift_reg[DATA_W + i*4 +: 4]);
  end

  // Digits only change in DONE, so a value change mid-conversion never
  // reaches the display as a partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      count        <= '0;
      digits       <= '0;
      digits_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shift_reg <= {16'd0, value};
          count     <= '0;
        end
        SHIFT: begin
          shift_reg <= {bcd_adj, shift_reg[DATA_W-1:0]} << 1;
          count     <= count + 4'd1;
        end
        DONE: begin
          digits       <= shift_reg[DATA_W +: 16];
          digits_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + REFRESH_BITS'(1);
  end

  assign sel = cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    cur_digit  = digits[15:12];
    anode_next = 4'b0111;
    case (sel)
      2'd0: begin cur_digit = digits[15:12]; anode_next = 4'b0111; end
      2'd1: begin cur_digit = digits[11:8];  anode_next = 4'b1011; end
      2'd2: begin cur_digit = digits[7:4];   anode_next = 4'b1101; end
      2'd3: begin cur_digit = digits[3:0];   anode_next = 4'b1110; end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .bcd (cur_digit),
    .seg (seg)
  );

  // Registered outputs keep the display dark until a full conversion exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Anode   <= ANODE_OFF;
      LED_out <= SEG_BLANK;
    end else if (!digits_valid) begin
      Anode   <= ANODE_OFF;
      LED_out <= SEG_BLANK;
    end else begin
      Anode   <= anode_next;
      LED_out <= seg;
    end
  end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed testbench for ssd_display_driver with a 4-bit refresh counter;
// expected digits and segment patterns are hand-computed constants.
module tb_ssd_display_driver;

  logic        clk;
  logic        rst;
  logic [12:0] value;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic        digits_valid;

  int total_checks;
  int bad_checks;
  int cyc;

  ssd_display_driver #(
    .REFRESH_BITS (4),
    .DATA_W       (13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .value        (value),
    .Anode        (Anode),
    .LED_out      (LED_out),
    .digits_valid (digits_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s at cyc %0d: got %0h, want %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [12:0] v);
    value = v;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Outputs after edge k reflect the counter value k-1 (registered, 1-cycle lag).
  task automatic runAndCheck(input int last_cyc, input logic [15:0] bcd);
    int sel;
    logic [3:0] d;
    logic [3:0] exp_anode;
    while (cyc < last_cyc) begin
      stepCycle();
      sel = ((cyc - 1) % 16) / 4;
      case (sel)
        0:       begin d = bcd[15:12]; exp_anode = 4'b0111; end
        1:       begin d = bcd[11:8];  exp_anode = 4'b1011; end
        2:       begin d = bcd[7:4];   exp_anode = 4'b1101; end
        default: begin d = bcd[3:0];   exp_anode = 4'b1110; end
      endcase
      checkOutput("anode", int'(Anode), int'(exp_anode));
      checkOutput("seg", int'(LED_out), int'(segOf(d)));
      checkOutput("valid", int'(digits_valid), 1);
    end
  endtask

  task automatic blankPhase();
    for (int i = 1; i <= 15; i++) begin
      stepCycle();
      checkOutput("blank_anode", int'(Anode), 4'hF);
      checkOutput("blank_seg", int'(LED_out), 7'h7F);
      checkOutput("blank_valid", int'(digits_valid), (i == 15) ? 1 : 0);
    end
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    cyc          = 0;
    rst          = 1'b1;
    applyStimulus(13'd1234);
    repeat (2) @(negedge clk);
    checkOutput("rst_anode", int'(Anode), 4'hF);
    checkOutput("rst_seg", int'(LED_out), 7'h7F);
    checkOutput("rst_valid", int'(digits_valid), 0);

    $display("[TB] releasing reset, value=1234");
    rst = 1'b0;
    cyc = 0;
    blankPhase();
    runAndCheck(35, 16'h1234);

    $display("[TB] value 1234 -> 5678 on 5th shift cycle");
    applyStimulus(13'd5678);
    runAndCheck(60, 16'h1234);
    runAndCheck(76, 16'h5678);

    $display("[TB] value 8191");
    applyStimulus(13'd8191);
    runAndCheck(105, 16'h5678);
    runAndCheck(121, 16'h8191);

    $display("[TB] value 0");
    applyStimulus(13'd0);
    runAndCheck(150, 16'h8191);
    runAndCheck(166, 16'h0000);

    $display("[TB] value 1234 then reset mid-shift");
    applyStimulus(13'd1234);
    runAndCheck(195, 16'h0000);
    runAndCheck(200, 16'h1234);
    rst = 1'b1;
    #1;
    checkOutput("async_anode", int'(Anode), 4'hF);
    checkOutput("async_seg", int'(LED_out), 7'h7F);
    checkOutput("async_valid", int'(digits_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    blankPhase();
    runAndCheck(40, 16'h1234);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/ssd_display_driver.md
Name: ssd_display_driver

Overview:
- Output stage downstream of pipelinedCPU; drives the board's 4-digit seven-segment display.
- Takes the 13-bit value the CPU selects via ssdSel and converts it to BCD with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the four digits onto Anode/LED_out.
- Runs on the CPU clock; the refresh rate is derived from an internal counter.

Parameters:
- REFRESH_BITS, 18: refresh counter width. The top 2 bits select the digit, so each digit is lit for 2^(REFRESH_BITS-2) cycles. Benches use 4.
- DATA_W, 13: input width. Fixed at 13 so the maximum value 8191 fits in 4 BCD digits. Other values are unsupported.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- value, input, DATA_W: unsigned binary value to display.
- Anode, output, 4: digit enables, active-low. Anode[3] is the leftmost (thousands) digit.
- LED_out, output, 7: segments, active-low. Bit 6 = a, bit 0 = g.
- digits_valid, output, 1: high once the first conversion after reset has completed.

Behaviour:
- Reset (async, rst=1):
  - FSM → IDLE; refresh counter = 0; shift register = 0; digit registers = 0.
  - Anode = 4'b1111; LED_out = 7'b1111111; digits_valid = 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE (1 cycle): capture value into the 13-bit binary shift field; clear the 16-bit BCD field; iteration count = 0; → SHIFT.
  - SHIFT (exactly 13 cycles): for each BCD nibble ≥ 5, add 3; then shift {bcd, bin} left by 1; increment count. After the 13th shift → DONE.
  - DONE (1 cycle): copy the BCD field into the four digit registers; set digits_valid = 1 (sticky until reset); → IDLE.
- Conversion period is 15 cycles, free-running. The value sampled in IDLE at cycle t appears in the digit registers at the clock edge ending cycle t+14.
- value changes during SHIFT/DONE are ignored. The new value is picked up at the next IDLE. There is no glitch on displayed digits, because they update only in DONE.
- Refresh counter:
  - Free-running REFRESH_BITS-bit up-counter; wraps from all-ones to 0 without a stall.
  - sel = cnt[REFRESH_BITS-1 -: 2].
  - sel 0 → Anode 4'b0111 (thousands); 1 → 4'b1011 (hundreds); 2 → 4'b1101 (tens); 3 → 4'b1110 (ones).
- Anode and LED_out are registered: they reflect the sel and digit registers of the previous cycle (1-cycle lag).
- While digits_valid = 0, Anode is held at 4'b1111 and LED_out at 7'b1111111.
- Segment encoding (gfedcba order reversed: [6]=a):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other nibble → 1111111 (unreachable, but decoded).
- No leading-zero blanking: 42 displays as 0,0,4,2.
- Reset mid-conversion: the partial result is discarded and the digits are cleared. After release, the first valid display appears 15 cycles later.

Decomposition:
- Package ssd_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - ANODE_OFF = 4'b1111;
  - the shift-count constant 13.
- One combinational sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low segments out), is instantiated once on the muxed digit.
- The FSM and refresh logic live in ssd_display_driver.

Test Plan:
- Reset with REFRESH_BITS=4 → Anode=1111, LED_out=1111111, digits_valid=0. Both outputs remain at these values for the first 15 cycles after rst falls.
- value=1234 held → digits_valid rises 15 cycles after reset release. Anode then cycles 0111/1011/1101/1110, each held 4 cycles, with LED_out=1001111/0010010/0000110/1001100 respectively.
- value=8191 → digits 8,1,9,1 (LED_out 0000000, 1001111, 0000100, 1001111). value=0 → all four digits show 0000001.
- value changes 1234→5678 on the 5th SHIFT cycle → displayed digits stay 1,2,3,4 for that conversion and show 5,6,7,8 after the following 15-cycle conversion. No intermediate values are ever displayed.
- Assert rst for 1 cycle mid-SHIFT while showing 1234 → outputs blank immediately (async), digits_valid=0, and the counter restarts at 0. Valid display resumes 15 cycles after release.
- Run 2^REFRESH_BITS+3 cycles → refresh counter wraps cleanly: the Anode sequence continues 1110→0111 with no skipped or double-length digit.
